debounce_pulse: RTL and testbench

- Input-conditioning stage that sits directly upstream of the delay/pulse generator. It turns a raw, bouncing, asynchronous push-button or contact input into clean single-cycle event pulses and a debounced level.
- press_pulse is the intended source for the delay stage's sig_in.
- Adds long-press detection and auto-repeat, so one physical button can drive several downstream delay/pulse stages.

---
 rtl/debounce_pulse.sv | 137 +++++++++++++
 tb/tb_debounce_pulse.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_pulse.sv
// Button conditioner: synchronizes and debounces a raw contact input, then
// emits press/release/long-press/auto-repeat single-cycle pulses.
module debounce_pulse #(
  parameter int CNT_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int LONG_CYCLES     = 50000,
  parameter int REPEAT_CYCLES   = 10000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam logic [CNT_WIDTH-1:0] DB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REP_LAST  = CNT_WIDTH'(REPEAT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ZERO      = '0;
  localparam logic INACTIVE = ACTIVE_LOW;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    HELD,
    REL_DB
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 sync_0;
  logic                 sync_1;
  logic                 p;
  logic                 held;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_0 <= INACTIVE;
      sync_1 <= INACTIVE;
    end else begin
      sync_0 <= btn_in;
      sync_1 <= sync_0;
    end
  end

  // Normalized pressed indication; everything below works on active-high p.
  assign p = sync_1 ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= ZERO;
      held          <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (p) begin
            state <= PRESS_DB;
            cnt   <= ZERO;
          end
        end
        PRESS_DB: begin
          if (!p) begin
            state <= IDLE;
            cnt   <= ZERO;
          end else if (cnt == DB_LAST) begin
            state       <= PRESSED;
            cnt         <= ZERO;
            press_pulse <= 1'b1;
            btn_level   <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        PRESSED: begin
          if (!p) begin
            state <= REL_DB;
            cnt   <= ZERO;
            held  <= 1'b0;
          end else if (cnt == LONG_LAST) begin
            state      <= HELD;
            cnt        <= ZERO;
            long_pulse <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        HELD: begin
          if (!p) begin
            state <= REL_DB;
            cnt   <= ZERO;
            held  <= 1'b1;
          end else if (cnt == REP_LAST) begin
            cnt          <= ZERO;
            repeat_pulse <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        REL_DB: begin
          // A release glitch returns to the hold phase we came from, timer restarted.
          if (p) begin
            state <= held ? HELD : PRESSED;
            cnt   <= ZERO;
          end else if (cnt == DB_LAST) begin
            state         <= IDLE;
            cnt           <= ZERO;
            release_pulse <= 1'b1;
            btn_level     <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_pulse.sv
// Bench for debounce_pulse: directed latency scenarios plus random bounce
// sequences compared against a run-length reference model.
module tb_debounce_pulse;

  localparam int D = 4;
  localparam int L = 10;
  localparam int R = 3;

  logic clk;
  logic reset;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  debounce_pulse #(
    .CNT_WIDTH      (16),
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .REPEAT_CYCLES  (R),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a press or release is accepted once the synchronized input
  // has disagreed with the accepted level for D+1 consecutive edges; hold time
  // counts agreeing edges since the last (re)entry into the pressed phase.
  bit [1:0] m_delay;
  bit       m_p;
  bit       m_level;
  int       m_run;
  int       m_hold;
  bit       m_long_done;
  bit       m_press, m_release, m_long, m_repeat;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_delay     = 2'b11;
      m_level     = 1'b0;
      m_run       = 0;
      m_hold      = 0;
      m_long_done = 1'b0;
      m_press     = 1'b0;
      m_release   = 1'b0;
      m_long      = 1'b0;
      m_repeat    = 1'b0;
    end else begin
      m_p       = !m_delay[1];
      m_delay   = {m_delay[0], btn_in};
      m_press   = 1'b0;
      m_release = 1'b0;
      m_long    = 1'b0;
      m_repeat  = 1'b0;
      if (!m_level) begin
        if (m_p) begin
          m_run++;
          if (m_run == D + 1) begin
            m_press     = 1'b1;
            m_level     = 1'b1;
            m_run       = 0;
            m_hold      = 0;
            m_long_done = 1'b0;
          end
        end else begin
          m_run = 0;
        end
      end else begin
        if (!m_p) begin
          m_run++;
          m_hold = 0;
          if (m_run == D + 1) begin
            m_release = 1'b1;
            m_level   = 1'b0;
            m_run     = 0;
          end
        end else if (m_run > 0) begin
          m_run  = 0;
          m_hold = 0;
        end else begin
          m_hold++;
          if (m_hold == (m_long_done ? R : L)) begin
            if (m_long_done) m_repeat = 1'b1;
            else             m_long   = 1'b1;
            m_long_done = 1'b1;
            m_hold      = 0;
          end
        end
      end
    end
  end

  task automatic check_value(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check_value("btn_level", int'(btn_level), int'(m_level));
    check_value("press_pulse", int'(press_pulse), int'(m_press));
    check_value("release_pulse", int'(release_pulse), int'(m_release));
    check_value("long_pulse", int'(long_pulse), int'(m_long));
    check_value("repeat_pulse", int'(repeat_pulse), int'(m_repeat));
    check_value("single_pulse",
                int'($countones({press_pulse, release_pulse, long_pulse, repeat_pulse}) <= 1), 1);
  endtask

  // Drive btn_in just after an edge, then sample 1 time unit after the next edge.
  task automatic apply_stimulus(input logic b);
    btn_in = b;
    @(posedge clk);
    #1;
    check_output();
  endtask

  int press_idx;
  int long_idx;
  int rel_idx;
  int rep_idx[$];
  bit seen;

  initial begin
    reset  = 1'b0;
    btn_in = 1'b1;

    // Reset held with a toggling input: everything stays quiet.
    for (int i = 0; i < 6; i++) apply_stimulus(logic'(i % 2));
    check_value("reset_level", int'(btn_level), 0);
    #1 reset = 1'b1;
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1);
    check_value("idle_level", int'(btn_level), 0);

    // Clean press held 30 cycles: press at 6, long at 16, repeats every 3.
    press_idx = -1;
    long_idx  = -1;
    rep_idx.delete();
    for (int i = 0; i < 30; i++) begin
      apply_stimulus(1'b0);
      if (press_pulse && press_idx < 0) press_idx = i;
      if (long_pulse && long_idx < 0) long_idx = i;
      if (repeat_pulse) rep_idx.push_back(i);
    end
    check_value("press_latency", press_idx, 6);
    check_value("long_latency", long_idx, 16);
    check_value("repeat_count", rep_idx.size(), 4);
    if (rep_idx.size() == 4) begin
      check_value("repeat_first", rep_idx[0], 19);
      check_value("repeat_last", rep_idx[3], 28);
    end

    // Release glitch while held: no release, level stays up.
    seen = 1'b0;
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b0);
      if (release_pulse || !btn_level) seen = 1'b1;
    end
    check_value("glitch_no_release", int'(seen), 0);

    // Clean release: release_pulse 6 cycles after the first inactive edge.
    rel_idx = -1;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1);
      if (release_pulse && rel_idx < 0) rel_idx = i;
    end
    check_value("release_latency", rel_idx, 6);
    check_value("released_level", int'(btn_level), 0);

    // Bounce shorter than the debounce window never produces a press.
    seen = 1'b0;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1);
      if (press_pulse || btn_level) seen = 1'b1;
    end
    check_value("bounce_rejected", int'(seen), 0);

    // Reset during PRESSED drops the level at once and never releases.
    for (int i = 0; i < 9; i++) apply_stimulus(1'b0);
    check_value("pressed_before_reset", int'(btn_level), 1);
    #2 reset = 1'b0;
    #1;
    check_value("async_reset_level", int'(btn_level), 0);
    check_output();
    for (int i = 0; i < 3; i++) apply_stimulus(logic'(i % 2));
    #1 reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1);
      if (release_pulse) seen = 1'b1;
    end
    check_value("no_release_after_reset", int'(seen), 0);

    // Random bouncing runs, some long enough to reach long press and repeats.
    for (int seg = 0; seg < 80; seg++) begin
      logic lvl;
      int   len;
      lvl = logic'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) apply_stimulus(lvl);
    end
    for (int i = 0; i < 12; i++) apply_stimulus(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
